// File: rtl/note_scanner_pkg.sv
// note_scanner_pkg: lane geometry, FSM state set and the row/lane -> x mapping.
package note_scanner_pkg;
  localparam int NUM_LANES = 5;
  localparam int X_BASE [NUM_LANES] = '{130, 145, 160, 175, 190};
  localparam int X_SLOPE [NUM_LANES] = '{-12, -6, 0, 6, 12};
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_CHECK, ST_ISSUE, ST_WAIT, ST_NEXT} state_t;
  // Lanes fan out from the centre column; lower rows spread wider.
  function automatic logic [8:0] lane_x(input logic [2:0] row, input logic [2:0] lane);
    int v;
    v = 0;
    for (int l = 0; l < NUM_LANES; l++)
      if (int'(lane) == l + 1) v = X_BASE[l] + X_SLOPE[l] * int'(row);
    return 9'(v);
  endfunction
endpackage

// File: rtl/note_scanner_if.sv
// note_scanner_if: grid-memory, plotter and frame-control signals of the note scanner.
// NOTE_SCANNER_PAUSE_EN adds the pause input.
interface note_scanner_if;
  logic       start;
  logic       clear_mode;
  logic [2:0] row_addr;
  logic [4:0] row_data;
  logic       plot_note;
  logic       clear_note;
  logic       enable_plotter;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic       plotter_done;
  logic       busy;
  logic       frame_done;
`ifdef NOTE_SCANNER_PAUSE_EN
  logic       pause;
`endif
  modport master (
`ifdef NOTE_SCANNER_PAUSE_EN
    output pause,
`endif
    output start, clear_mode, row_data, plotter_done,
    input  row_addr, plot_note, clear_note, enable_plotter, x_out, y_out, busy, frame_done
  );
  modport slave (
`ifdef NOTE_SCANNER_PAUSE_EN
    input  pause,
`endif
    input  start, clear_mode, row_data, plotter_done,
    output row_addr, plot_note, clear_note, enable_plotter, x_out, y_out, busy, frame_done
  );
endinterface

// File: rtl/note_scanner_lane_xy.sv
// lane_xy: combinational screen origin of the note at (row, lane).
module lane_xy
  import note_scanner_pkg::*;
#(
  parameter int Y_BASE  = 40,
  parameter int Y_PITCH = 26
) (
  input  logic [2:0] i_row,
  input  logic [2:0] i_lane,
  output logic [8:0] o_x,
  output logic [7:0] o_y
);
  always_comb begin
    o_x = lane_x(i_row, i_lane);
    o_y = 8'(Y_BASE + Y_PITCH * int'(i_row));
  end
endmodule

// File: rtl/note_scanner.sv
// note_scanner: scans the note grid row by row, issuing one plot/clear command per set lane bit.
// Optional macro NOTE_SCANNER_PAUSE_EN adds a pause input that stalls FETCH, CHECK and NEXT.
module note_scanner
  import note_scanner_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int Y_BASE   = 40,
  parameter int Y_PITCH  = 26
) (
  input logic          clk,
  input logic          resetn,
  note_scanner_if.slave bus
);
  localparam logic [2:0] IDLE      = ST_IDLE;
  localparam logic [2:0] FETCH     = ST_FETCH;
  localparam logic [2:0] LATCH     = ST_LATCH;
  localparam logic [2:0] CHECK     = ST_CHECK;
  localparam logic [2:0] ISSUE     = ST_ISSUE;
  localparam logic [2:0] WAIT      = ST_WAIT;
  localparam logic [2:0] NEXT      = ST_NEXT;
  localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);
  localparam logic [2:0] LAST_LANE = 3'(NUM_LANES);
  logic [2:0] r_state, r_row, r_lane;
  logic [4:0] r_buf;
  logic       r_mode, r_en, r_plot, r_clr, r_done;
  logic [8:0] r_x, w_x;
  logic [7:0] r_y, w_y;
  logic       w_pause, w_bit;
`ifdef NOTE_SCANNER_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif
  assign w_bit              = r_buf[r_lane - 3'd1];
  assign bus.row_addr       = r_row;
  assign bus.x_out          = r_x;
  assign bus.y_out          = r_y;
  assign bus.enable_plotter = r_en;
  assign bus.plot_note      = r_plot;
  assign bus.clear_note     = r_clr;
  assign bus.busy           = r_state != IDLE;
  assign bus.frame_done     = r_done;
  lane_xy #(.Y_BASE(Y_BASE), .Y_PITCH(Y_PITCH)) u_xy (
    .i_row (r_row),
    .i_lane(r_lane),
    .o_x   (w_x),
    .o_y   (w_y)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_lane  <= '0;
      r_buf   <= '0;
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_en    <= 1'b0;
      r_plot  <= 1'b0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= FETCH;
          r_row   <= '0;
          r_lane  <= 3'd1;
          r_mode  <= bus.clear_mode;
        end
        FETCH: if (!w_pause) r_state <= LATCH;
        LATCH: begin
          r_buf   <= bus.row_data;
          r_state <= CHECK;
        end
        CHECK: if (!w_pause) r_state <= w_bit ? ISSUE : NEXT;
        ISSUE: begin
          r_x     <= w_x;
          r_y     <= w_y;
          r_en    <= 1'b1;
          r_plot  <= !r_mode;
          r_clr   <= r_mode;
          r_state <= WAIT;
        end
        // Command drops on the done edge; NEXT/CHECK/ISSUE then guarantee a low gap.
        WAIT: if (bus.plotter_done) begin
          r_en    <= 1'b0;
          r_plot  <= 1'b0;
          r_clr   <= 1'b0;
          r_state <= NEXT;
        end
        NEXT: if (!w_pause) begin
          if (r_lane < LAST_LANE) begin
            r_lane  <= r_lane + 3'd1;
            r_state <= CHECK;
          end else if (r_row < LAST_ROW) begin
            r_row   <= r_row + 3'd1;
            r_lane  <= 3'd1;
            r_state <= FETCH;
          end else begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_scanner.sv
// tb_note_scanner: randomized frames checked cycle by cycle against a command-list/timing model.
module tb_note_scanner;
  localparam int N = 8;
  typedef struct { int x; int y; bit clr; } cmd_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  note_scanner_if bus();
  note_scanner dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  logic [4:0] grid [N];
  cmd_t q[$];
  cmd_t c_exp;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int d_fix = 0, d = 1, wait_cnt = 0;
  int t0 = 0, exp_end = 0, frame_len = 0, frames = 0;
  int f_cmds = 0, f_plot_hi = 0, f_x160 = 0;
  int last_x = 0, last_y = 0, last_clr = 0, cap_x = 0, cap_y = 0;
  bit exp_busy = 0, accept_pending = 0, prev_en = 0, prev_pd = 0, no_time = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.row_data <= grid[bus.row_addr];

  function automatic int model_x(int r, int lane);
    return 130 + 15 * (lane - 1) + 6 * r * (lane - 3);
  endfunction
  function automatic int model_y(int r);
    return (40 + 26 * r) % 256;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: expected command list from the grid, frame end = 12 cycles/row + (1+wait) per note.
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      exp_busy = 0; accept_pending = 0; prev_en = 0; prev_pd = 0;
      bus.plotter_done = 1'b0;
    end else begin
      if (accept_pending) begin accept_pending = 0; exp_busy = 1; end
      if (bus.frame_done) begin
        check("done_in_frame", exp_busy, 1);
        check("done_pending_cmds", q.size(), 0);
        if (!no_time) check("frame_time", cyc, exp_end);
        frame_len = cyc - t0;
        frames++;
        exp_busy = 0;
      end
      check("busy", bus.busy, exp_busy);
      check("en_vs_cmd", bus.enable_plotter, bus.plot_note | bus.clear_note);
      check("cmd_onehot", bus.plot_note & bus.clear_note, 0);
      if (prev_pd && prev_en) check("drop_on_done", bus.enable_plotter, 0);
      if (bus.enable_plotter && !prev_en) begin
        check("cmd_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          c_exp = q.pop_front();
          check("x_out", bus.x_out, c_exp.x);
          check("y_out", bus.y_out, c_exp.y);
          check("plot_note", bus.plot_note, !c_exp.clr);
          check("clear_note", bus.clear_note, c_exp.clr);
        end
        cap_x = bus.x_out; cap_y = bus.y_out;
        last_x = bus.x_out; last_y = bus.y_out; last_clr = bus.clear_note;
        f_cmds++;
        if (bus.x_out == 9'd160) f_x160++;
        d = d_fix != 0 ? d_fix : $urandom_range(1, 4);
        wait_cnt = 0;
        exp_end += 1 + d;
      end else if (bus.enable_plotter) begin
        check("x_hold", bus.x_out, cap_x);
        check("y_hold", bus.y_out, cap_y);
      end
      if (bus.plot_note) f_plot_hi++;
      prev_en = bus.enable_plotter;
      if (bus.enable_plotter) begin
        wait_cnt++;
        bus.plotter_done = wait_cnt == d;
      end else bus.plotter_done = $urandom_range(0, 7) == 0;
      prev_pd = bus.plotter_done;
      if (bus.start && !exp_busy && !accept_pending) begin
        accept_pending = 1;
        t0 = cyc + 1;
        exp_end = t0 + 12 * N;
        f_cmds = 0; f_plot_hi = 0; f_x160 = 0;
        q.delete();
        for (int r = 0; r < N; r++)
          for (int l = 1; l <= 5; l++)
            if (grid[r][l-1]) q.push_back('{model_x(r, l), model_y(r), bus.clear_mode});
      end
    end
  end

  task automatic chk_quiet(input string tag);
    check({tag, "_row_addr"}, bus.row_addr, 0);
    check({tag, "_x"}, bus.x_out, 0);
    check({tag, "_y"}, bus.y_out, 0);
    check({tag, "_plot"}, bus.plot_note, 0);
    check({tag, "_clear"}, bus.clear_note, 0);
    check({tag, "_en"}, bus.enable_plotter, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.frame_done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 resetn = 1'b0;
    #1 chk_quiet("reset");
    @(posedge clk); #2 resetn = 1'b1;
  endtask

  task automatic set_grid(input logic [4:0] v);
    for (int r = 0; r < N; r++) grid[r] = v;
  endtask

  task automatic pulse_start(input bit mode);
    @(posedge clk); #1 bus.start = 1'b1; bus.clear_mode = mode;
    @(posedge clk); #1 bus.start = 1'b0; bus.clear_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input bit mode);
    int f0;
    f0 = frames;
    pulse_start(mode);
    for (int i = 0; i < 1000 && frames == f0; i++) begin
      @(posedge clk); #1;
      bus.start = bus.busy && ($urandom_range(0, 15) == 0);
    end
    bus.start = 1'b0;
    check("frame_finished", frames - f0, 1);
    if (frames == f0) do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.clear_mode = 1'b0;
`ifdef NOTE_SCANNER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    set_grid(5'b0);
    repeat (2) @(posedge clk);
    #1 chk_quiet("por");
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);

    d_fix = 3;
    grid[0] = 5'b00001;
    run_frame(1'b0);
    check("draw_cmds", f_cmds, 1);
    check("draw_x", last_x, 130);
    check("draw_y", last_y, 40);
    check("draw_is_plot", last_clr, 0);
    check("draw_len", frame_len, 100);

    set_grid(5'b0);
    grid[7] = 5'b10000;
    run_frame(1'b1);
    check("clear_cmds", f_cmds, 1);
    check("clear_x", last_x, 274);
    check("clear_y", last_y, 222);
    check("clear_is_clear", last_clr, 1);
    check("clear_plot_never", f_plot_hi, 0);
    check("clear_len", frame_len, 100);

    set_grid(5'b0);
    run_frame(1'b0);
    check("empty_cmds", f_cmds, 0);
    check("empty_len", frame_len, 12 * N);

    d_fix = 0;
    set_grid(5'b11111);
    run_frame(1'b0);
    check("full_cmds", f_cmds, 40);
    check("full_lane3_160", f_x160, 8);

    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < N; r++) grid[r] = 5'($urandom);
      run_frame(1'($urandom_range(0, 1)));
    end

    d_fix = 4;
    set_grid(5'b0);
    grid[0] = 5'b00011;
    grid[3] = 5'b00100;
    pulse_start(1'b0);
    for (int i = 0; i < 200 && f_cmds < 2; i++) @(negedge clk);
    check("rst_reached_wait2", f_cmds, 2);
    begin
      int f0;
      f0 = frames;
      do_reset();
      repeat (40) @(posedge clk);
      #1 check("rst_no_done", frames - f0, 0);
      chk_quiet("rst_after");
    end

`ifdef NOTE_SCANNER_PAUSE_EN
    d_fix = 3;
    no_time = 1;
    set_grid(5'b0);
    grid[0] = 5'b00011;
    pulse_start(1'b0);
    for (int i = 0; i < 200 && f_cmds < 1; i++) @(negedge clk);
    @(posedge clk); #1 bus.pause = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("pause_note_done", bus.enable_plotter, 0);
    check("pause_no_next", f_cmds, 1);
    bus.pause = 1'b0;
    begin
      int f0;
      f0 = frames;
      for (int i = 0; i < 500 && frames == f0; i++) @(posedge clk);
      #1 check("pause_frame_done", frames - f0, 1);
    end
    check("pause_cmds", f_cmds, 2);
    no_time = 0;
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
